btn_reader: RTL and testbench
=============================

# btn_reader

Debounced multi-channel push-button/switch input block, the input-side counterpart to the board LED output driver. It samples raw asynchronous board pins, synchronizes and debounces each one, and produces a clean level plus single-cycle press, release and long-press pulses for the rest of the design. Each channel is independent.

## Interface

- N_BTN, 4, number of button channels
- DEBOUNCE_CYC, 500000, consecutive stable cycles required to accept a change (10 ms @ 50 MHz); legal ≥ 2
- LONG_CYC, 50000000, hold cycles after press acceptance before long_press fires (1 s @ 50 MHz); legal ≥ 2
- ACTIVE_LOW, 0, 1 = pin reads 0 when pressed; inverted before the synchronizer

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pins_in  in  N_BTN  raw asynchronous button pins
- level  out  N_BTN  debounced pressed state, 1 = pressed
- press  out  N_BTN  1-cycle pulse on accepted press
- release  out  N_BTN  1-cycle pulse on accepted release
- long_press  out  N_BTN  1-cycle pulse, at most once per press
- was_long  out  N_BTN  on a release pulse: 1 if long_press fired during that press; otherwise 0

## Operation

- Per channel: polarity-correct → 2-FF synchronizer (s1, s2) → FSM with debounce counter dcnt and hold counter hcnt.
- RELEASED: level=0. s2=1 → PRESS_PEND, dcnt=0.
- PRESS_PEND: s2=0 → RELEASED (bounce rejected, no pulse). s2=1 and dcnt==DEBOUNCE_CYC-1 → PRESSED, press=1, level=1, hcnt=0, long flag=0. Otherwise dcnt++.
- PRESSED: s2=0 → RELEASE_PEND, dcnt=0. s2=1 and hcnt==LONG_CYC-1 → LONG_HELD, long_press=1, long flag=1. Otherwise hcnt++.
- LONG_HELD: s2=0 → RELEASE_PEND, dcnt=0. hcnt frozen.
- RELEASE_PEND: level stays 1; hcnt frozen. s2=1 → back to PRESSED if long flag=0, else LONG_HELD. s2=0 and dcnt==DEBOUNCE_CYC-1 → RELEASED, release=1, was_long=long flag, level=0. Otherwise dcnt++.
- Counter width: $clog2(max(DEBOUNCE_CYC, LONG_CYC)); no wrap is possible because both counters are compared before incrementing.
- press, release and long_press are never asserted in the same cycle on one channel.

## Timing

- All outputs are registered. Reset value of all outputs is 0, s1/s2 are 0, FSM is RELEASED, and counters are 0.
- Press latency: pin asserted before edge 0 and held → press and level high after edge DEBOUNCE_CYC+2. Release latency is the same.
- A glitch whose s2 high run is shorter than DEBOUNCE_CYC+1 cycles produces no output.
- long_press fires exactly LONG_CYC edges after the press pulse edge, provided no release bounce intervenes. RELEASE_PEND time does not count toward the hold.
- Reset mid-operation: outputs drop to 0 immediately (asynchronously). A pin still held after rst deasserts yields press at DEBOUNCE_CYC+2 edges after the first post-reset edge.
- Channels with simultaneous events operate independently, with no arbitration between them.

## Structure

- Package btn_pkg: typedef enum btn_state_t {RELEASED, PRESS_PEND, PRESSED, LONG_HELD, RELEASE_PEND}.
- Sub-module btn_chan: one channel (sync, FSM, counters). btn_reader is a generate loop of N_BTN btn_chan instances plus ACTIVE_LOW inversion.

## Test plan

Bench settings: DEBOUNCE_CYC=4, LONG_CYC=10, N_BTN=4.

- Clean press on pin0, held 30 cycles, then released → press pulse after edge 6, level=1; long_press at edge 16; release pulse 6 edges after the pin drops, with was_long=1.
- Pin1 bounce high for 3 cycles, low, repeated 5 times → no pulses, level stays 0.
- Short press on pin2, held 8 cycles → press then release, no long_press, was_long=0.
- Pin0 held, with a 2-cycle low glitch at hold cycle 5 → no release; long_press delayed by the 2 frozen-hold cycles plus synchronizer gap, fires exactly once.
- rst asserted mid-PRESSED with pin held → outputs 0 immediately; press again 6 edges after rst drops.
- ACTIVE_LOW=1, all four pins driven low simultaneously → four press pulses in the same cycle.

Source files
------------

// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the debounced button reader: per-channel FSM state
// encoding and the helper that sizes the debounce/hold counters.
// ---------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [2:0] {
      RELEASED     = 3'd0,
      PRESS_PEND   = 3'd1,
      PRESSED      = 3'd2,
      LONG_HELD    = 3'd3,
      RELEASE_PEND = 3'd4
   } btn_state_t;

   // Width able to hold max(a, b) - 1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/btn_chan.sv
// ---------------------------------------------------------------------------
// btn_chan
// One button channel: 2-FF synchronizer, debounce FSM, debounce counter and
// long-press hold counter. Input is already polarity-corrected (1 = pressed).
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   pin          raw (asynchronous) pressed indication
//   level        debounced pressed state
//   press        1-cycle pulse on accepted press
//   release_evt  1-cycle pulse on accepted release ("release" is a reserved word)
//   long_press   1-cycle pulse once per press after the hold time
//   was_long     valid with release_evt: long_press fired during that press
// ---------------------------------------------------------------------------
module btn_chan
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 500000,
   parameter int unsigned LONG_CYC     = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic press,
   output logic release_evt,
   output logic long_press,
   output logic was_long
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYC, LONG_CYC);
   localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] L_LAST = CW'(LONG_CYC - 1);

   logic          s1, s2;
   btn_state_t    state;
   logic [CW-1:0] dcnt;
   logic [CW-1:0] hcnt;
   logic          long_flag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= pin;
         s2 <= s1;
      end
   end

   // Counters are compared before incrementing, so they never wrap.
   // hcnt is left untouched in LONG_HELD and RELEASE_PEND, which is what
   // makes a release bounce pause (rather than restart) the hold time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RELEASED;
         dcnt        <= '0;
         hcnt        <= '0;
         long_flag   <= 1'b0;
         level       <= 1'b0;
         press       <= 1'b0;
         release_evt <= 1'b0;
         long_press  <= 1'b0;
         was_long    <= 1'b0;
      end else begin
         press       <= 1'b0;
         release_evt <= 1'b0;
         long_press  <= 1'b0;
         was_long    <= 1'b0;
         case (state)
            RELEASED: begin
               if (s2) begin
                  state <= PRESS_PEND;
                  dcnt  <= '0;
               end
            end
            PRESS_PEND: begin
               if (!s2) begin
                  state <= RELEASED;
               end else if (dcnt == D_LAST) begin
                  state     <= PRESSED;
                  press     <= 1'b1;
                  level     <= 1'b1;
                  hcnt      <= '0;
                  long_flag <= 1'b0;
               end else begin
                  dcnt <= dcnt + CW'(1);
               end
            end
            PRESSED: begin
               if (!s2) begin
                  state <= RELEASE_PEND;
                  dcnt  <= '0;
               end else if (hcnt == L_LAST) begin
                  state      <= LONG_HELD;
                  long_press <= 1'b1;
                  long_flag  <= 1'b1;
               end else begin
                  hcnt <= hcnt + CW'(1);
               end
            end
            LONG_HELD: begin
               if (!s2) begin
                  state <= RELEASE_PEND;
                  dcnt  <= '0;
               end
            end
            RELEASE_PEND: begin
               if (s2) begin
                  state <= long_flag ? LONG_HELD : PRESSED;
               end else if (dcnt == D_LAST) begin
                  state       <= RELEASED;
                  release_evt <= 1'b1;
                  was_long    <= long_flag;
                  level       <= 1'b0;
               end else begin
                  dcnt <= dcnt + CW'(1);
               end
            end
            default: state <= RELEASED;
         endcase
      end
   end

endmodule

// File: rtl/btn_reader.sv
// ---------------------------------------------------------------------------
// btn_reader
// Debounced multi-channel push-button/switch reader. Each pin is polarity
// corrected, then handled by an independent btn_chan instance.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   pins_in      raw asynchronous button pins            [N_BTN]
//   level        debounced pressed state, 1 = pressed    [N_BTN]
//   press        1-cycle pulse on accepted press         [N_BTN]
//   release_evt  1-cycle pulse on accepted release       [N_BTN]
//                ("release" is a reserved word)
//   long_press   1-cycle pulse, at most once per press   [N_BTN]
//   was_long     with release_evt: long press occurred   [N_BTN]
// ---------------------------------------------------------------------------
module btn_reader #(
   parameter int unsigned N_BTN        = 4,
   parameter int unsigned DEBOUNCE_CYC = 500000,
   parameter int unsigned LONG_CYC     = 50000000,
   parameter bit          ACTIVE_LOW   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] pins_in,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press,
   output logic [N_BTN-1:0] release_evt,
   output logic [N_BTN-1:0] long_press,
   output logic [N_BTN-1:0] was_long
);

   logic [N_BTN-1:0] pins_act;

   assign pins_act = ACTIVE_LOW ? ~pins_in : pins_in;

   for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      btn_chan #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .LONG_CYC     (LONG_CYC)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .pin         (pins_act[g]),
         .level       (level[g]),
         .press       (press[g]),
         .release_evt (release_evt[g]),
         .long_press  (long_press[g]),
         .was_long    (was_long[g])
      );
   end

endmodule

// File: tb/tb_btn_reader.sv
// ---------------------------------------------------------------------------
// tb_btn_reader
// Directed bench for btn_reader with DEBOUNCE_CYC=4, LONG_CYC=10, N_BTN=4.
// Edge numbering: pins set before edge 0; events are logged by edge index.
// ---------------------------------------------------------------------------
module tb_btn_reader;

   localparam int unsigned NB = 4;
   localparam int unsigned DB = 4;
   localparam int unsigned LC = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] pins    = '0;
   logic [NB-1:0] pins_al = '1;
   logic [NB-1:0] level, press, rel, lp, wl;
   logic [NB-1:0] level_al, press_al, rel_al, lp_al, wl_al;

   int tests = 0;
   int fails = 0;
   int e;
   int pcnt[NB], pe[NB], rcnt[NB], re[NB], lcnt[NB], le[NB], wlr[NB], lvl_hi[NB];
   int multi, wl_stray;
   int al_cnt, al_edge;
   logic [NB-1:0] al_val;

   btn_reader #(
      .N_BTN        (NB),
      .DEBOUNCE_CYC (DB),
      .LONG_CYC     (LC),
      .ACTIVE_LOW   (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pins_in     (pins),
      .level       (level),
      .press       (press),
      .release_evt (rel),
      .long_press  (lp),
      .was_long    (wl)
   );

   btn_reader #(
      .N_BTN        (NB),
      .DEBOUNCE_CYC (DB),
      .LONG_CYC     (LC),
      .ACTIVE_LOW   (1'b1)
   ) dut_al (
      .clk         (clk),
      .rst         (rst),
      .pins_in     (pins_al),
      .level       (level_al),
      .press       (press_al),
      .release_evt (rel_al),
      .long_press  (lp_al),
      .was_long    (wl_al)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      e        = -1;
      multi    = 0;
      wl_stray = 0;
      al_cnt   = 0;
      al_edge  = -1;
      al_val   = '0;
      for (int c = 0; c < NB; c++) begin
         pcnt[c] = 0; pe[c] = -1; rcnt[c] = 0; re[c] = -1;
         lcnt[c] = 0; le[c] = -1; wlr[c] = -1; lvl_hi[c] = 0;
      end
   endtask

   // Advance one edge and log every output event of the main instance.
   task automatic step();
      @(posedge clk);
      e++;
      #1;
      for (int c = 0; c < NB; c++) begin
         if (press[c]) begin pcnt[c]++; pe[c] = e; end
         if (rel[c])   begin rcnt[c]++; re[c] = e; wlr[c] = int'(wl[c]); end
         if (lp[c])    begin lcnt[c]++; le[c] = e; end
         if (level[c]) lvl_hi[c]++;
         if (int'(press[c]) + int'(rel[c]) + int'(lp[c]) > 1) multi++;
         if (wl[c] && !rel[c]) wl_stray++;
      end
      if (press_al != '0) begin
         al_cnt++;
         al_edge = e;
         al_val  = press_al;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #12;
      check("rst_level", level, 0);
      check("rst_press", press, 0);
      check("rst_release", rel, 0);
      check("rst_long", lp, 0);
      check("rst_waslong", wl, 0);
      check("rst_level_al", level_al, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: clean long press on pin0, held 30 cycles
      clear_log();
      for (int i = 0; i < 45; i++) begin
         pins[0] = (i < 30);
         step();
         if (i == 5)  check("s1_level_pre", level[0], 0);
         if (i == 6)  check("s1_level_on", level[0], 1);
         if (i == 35) check("s1_level_hold", level[0], 1);
         if (i == 36) check("s1_level_off", level[0], 0);
      end
      check("s1_press_cnt", pcnt[0], 1);
      check("s1_press_edge", pe[0], 6);
      check("s1_long_cnt", lcnt[0], 1);
      check("s1_long_edge", le[0], 16);
      check("s1_rel_cnt", rcnt[0], 1);
      check("s1_rel_edge", re[0], 36);
      check("s1_was_long", wlr[0], 1);
      check("s1_overlap", multi, 0);
      check("s1_waslong_stray", wl_stray, 0);

      // 2: bounce on pin1, 3 high / 3 low, five times
      clear_log();
      for (int i = 0; i < 40; i++) begin
         pins[1] = (i < 30) && ((i % 6) < 3);
         step();
      end
      check("s2_press_cnt", pcnt[1], 0);
      check("s2_rel_cnt", rcnt[1], 0);
      check("s2_long_cnt", lcnt[1], 0);
      check("s2_level_hi", lvl_hi[1], 0);

      // 3: short press on pin2, held 8 cycles
      clear_log();
      for (int i = 0; i < 20; i++) begin
         pins[2] = (i < 8);
         step();
      end
      check("s3_press_edge", pe[2], 6);
      check("s3_rel_cnt", rcnt[2], 1);
      check("s3_rel_edge", re[2], 14);
      check("s3_long_cnt", lcnt[2], 0);
      check("s3_was_long", wlr[2], 0);
      check("s3_waslong_stray", wl_stray, 0);

      // 4: pin0 held with a 2-cycle low glitch early in the hold
      clear_log();
      for (int i = 0; i < 50; i++) begin
         pins[0] = (i < 40) && !(i == 11 || i == 12);
         step();
      end
      check("s4_press_cnt", pcnt[0], 1);
      check("s4_press_edge", pe[0], 6);
      check("s4_long_cnt", lcnt[0], 1);
      check("s4_long_edge", le[0], 19);
      check("s4_rel_cnt", rcnt[0], 1);
      check("s4_rel_edge", re[0], 46);
      check("s4_was_long", wlr[0], 1);
      check("s4_overlap", multi, 0);

      // 5: reset mid-PRESSED with pin0 held
      clear_log();
      for (int i = 0; i < 11; i++) begin
         pins[0] = 1'b1;
         step();
      end
      check("s5_level_before", level[0], 1);
      #1;
      rst = 1'b1;
      #1;
      check("s5_async_level", level, 0);
      check("s5_async_pulses", {press, rel, lp, wl}, 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_log();
      for (int i = 0; i < 10; i++) step();
      check("s5_press_cnt", pcnt[0], 1);
      check("s5_press_edge", pe[0], 6);
      pins[0] = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("s5_level_final", level[0], 0);

      // 6: active-low instance, all four pins pressed together
      clear_log();
      for (int i = 0; i < 10; i++) begin
         pins_al = '0;
         step();
      end
      check("s6_press_cnt", al_cnt, 1);
      check("s6_press_edge", al_edge, 6);
      check("s6_press_val", al_val, 4'hF);
      check("s6_level", level_al, 4'hF);
      pins_al = '1;
      for (int i = 0; i < 10; i++) step();
      check("s6_level_off", level_al, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
